// File: rtl/data_status_pipe_vr.sv
// data_status_pipe_vr
// Valid/ready pipeline that carries a data word and a status word through
// R registered stages. Each stage advances on its own, so bubbles collapse.
// Every stage can be observed on the taps.
//
// Parameters:
//   DATA_W          data width per stage
//   STATUS_W        status width per stage
//   PIPE_DEPTH      number of tap entries (>=1)
//   INCLUDE_DATA_IN 1: tap[0] is the raw input and R = PIPE_DEPTH-1
//                   0: R = PIPE_DEPTH
//
// Ports:
//   clk, rst_n                    clock and asynchronous active-low reset
//   flush                         synchronous clear of all stages
//   in_valid/in_ready/data_i/status_i     input handshake and payload
//   out_valid/out_ready/data_o/status_o   last-stage handshake and payload
//   valid_tap_o/data_tap_o/status_tap_o   per-tap view
//   count_o                       registered number of valid stages
//
// Build option:
//   DATA_STATUS_PIPE_DATA_RST_EN  when defined, the data registers are also
//   reset and flushed to zero. Otherwise they are never reset or flushed.
module data_status_pipe_vr #(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned STATUS_W        = 1,
  parameter int unsigned PIPE_DEPTH      = 1,
  parameter int unsigned INCLUDE_DATA_IN = 0,
  localparam int unsigned R              = PIPE_DEPTH - INCLUDE_DATA_IN,
  localparam int unsigned CNT_W          = (R == 0) ? 1 : $clog2(R + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_W-1:0]                    data_i,
  input  logic [STATUS_W-1:0]                  status_i,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_W-1:0]                    data_o,
  output logic [STATUS_W-1:0]                  status_o,
  output logic [PIPE_DEPTH-1:0]                valid_tap_o,
  output logic [PIPE_DEPTH-1:0][DATA_W-1:0]    data_tap_o,
  output logic [PIPE_DEPTH-1:0][STATUS_W-1:0]  status_tap_o,
  output logic [CNT_W-1:0]                     count_o
);

  if (R == 0) begin : g_wire
    // No registered stage: the block is a pure wire.
    assign out_valid       = in_valid;
    assign data_o          = data_i;
    assign status_o        = status_i;
    assign in_ready        = out_ready;
    assign count_o         = '0;
    assign valid_tap_o     = in_valid;
    assign data_tap_o[0]   = data_i;
    assign status_tap_o[0] = status_i;
  end else begin : g_pipe
    logic [R-1:0]                 r_v;
    logic [R-1:0][DATA_W-1:0]     r_d;
    logic [R-1:0][STATUS_W-1:0]   r_s;
    logic [CNT_W-1:0]             r_count;

    logic [R-1:0]                 w_move;
    logic [R-1:0]                 w_take;
    logic [R-1:0]                 w_pv;
    logic [R-1:0][DATA_W-1:0]     w_pd;
    logic [R-1:0][STATUS_W-1:0]   w_ps;
    logic [R-1:0]                 w_v_nxt;
    logic [R-1:0][DATA_W-1:0]     w_d_nxt;
    logic [R-1:0][STATUS_W-1:0]   w_s_nxt;
    logic [CNT_W-1:0]             w_count_nxt;

    // Ready ripples from out_ready back to stage 0: a stage can take a word
    // when it is empty or its own word leaves this cycle.
    always_comb begin : p_ready
      logic rdy;
      w_move = '0;
      w_take = '0;
      rdy    = out_ready;
      for (int k = int'(R) - 1; k >= 0; k--) begin
        w_move[k] = r_v[k] & rdy;
        w_take[k] = ~r_v[k] | w_move[k];
        rdy       = w_take[k];
      end
    end

    assign in_ready = w_take[0] & ~flush;

    // Predecessor of each stage: the input for stage 0, stage k-1 otherwise.
    always_comb begin : p_pred
      w_pv    = '0;
      w_pd    = '0;
      w_ps    = '0;
      w_pv[0] = in_valid;
      w_pd[0] = data_i;
      w_ps[0] = status_i;
      for (int k = 1; k < int'(R); k++) begin
        w_pv[k] = r_v[k-1];
        w_pd[k] = r_d[k-1];
        w_ps[k] = r_s[k-1];
      end
    end

    // Next stage contents; flush overrides every load and drain.
    always_comb begin : p_next
      w_v_nxt = r_v;
      w_d_nxt = r_d;
      w_s_nxt = r_s;
      if (flush) begin
        w_v_nxt = '0;
        w_s_nxt = '0;
`ifdef DATA_STATUS_PIPE_DATA_RST_EN
        w_d_nxt = '0;
`endif
      end else begin
        for (int k = 0; k < int'(R); k++) begin
          if (w_take[k] && w_pv[k]) begin
            w_v_nxt[k] = 1'b1;
            w_d_nxt[k] = w_pd[k];
            w_s_nxt[k] = w_ps[k];
          end else if (w_move[k]) begin
            // Drained with no refill: data keeps its stale value.
            w_v_nxt[k] = 1'b0;
            w_s_nxt[k] = '0;
          end
        end
      end
    end

    // Population count of the next valids, registered alongside them.
    always_comb begin : p_count
      w_count_nxt = '0;
      for (int k = 0; k < int'(R); k++) begin
        w_count_nxt = w_count_nxt + CNT_W'(w_v_nxt[k]);
      end
    end

    // Valid, status and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v     <= '0;
        r_s     <= '0;
        r_count <= '0;
      end else begin
        r_v     <= w_v_nxt;
        r_s     <= w_s_nxt;
        r_count <= w_count_nxt;
      end
    end

    // Data registers.
`ifdef DATA_STATUS_PIPE_DATA_RST_EN
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_d <= '0;
      end else begin
        r_d <= w_d_nxt;
      end
    end
`else
    always_ff @(posedge clk) begin
      r_d <= w_d_nxt;
    end
`endif

    assign out_valid = r_v[R-1];
    assign data_o    = r_d[R-1];
    assign status_o  = r_s[R-1];
    assign count_o   = r_count;

    // Tap mapping: optional raw-input tap first, then the stages in order.
    for (genvar i = 0; i < int'(PIPE_DEPTH); i++) begin : g_tap
      if (INCLUDE_DATA_IN != 0 && i == 0) begin : g_in
        assign valid_tap_o[i]  = in_valid;
        assign data_tap_o[i]   = data_i;
        assign status_tap_o[i] = status_i;
      end else begin : g_stage
        localparam int SI = i - int'(INCLUDE_DATA_IN);
        assign valid_tap_o[i]  = r_v[SI];
        assign data_tap_o[i]   = r_d[SI];
        assign status_tap_o[i] = r_s[SI];
      end
    end
  end

endmodule

// File: tb/tb_data_status_pipe_vr.sv
// Directed bench for data_status_pipe_vr: a 4-stage pipe (DATA_W=8,
// STATUS_W=2) and a wire-mode instance (PIPE_DEPTH=1, INCLUDE_DATA_IN=1).
module tb_data_status_pipe_vr;

  logic             clk;
  logic             clk_en;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       data_i;
  logic [1:0]       status_i;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       data_o;
  logic [1:0]       status_o;
  logic [3:0]       valid_tap_o;
  logic [3:0][7:0]  data_tap_o;
  logic [3:0][1:0]  status_tap_o;
  logic [2:0]       count_o;

  logic             w_in_valid;
  logic             w_in_ready;
  logic [7:0]       w_data_i;
  logic [1:0]       w_status_i;
  logic             w_out_valid;
  logic             w_out_ready;
  logic [7:0]       w_data_o;
  logic [1:0]       w_status_o;
  logic [0:0]       w_valid_tap_o;
  logic [0:0][7:0]  w_data_tap_o;
  logic [0:0][1:0]  w_status_tap_o;
  logic [0:0]       w_count_o;

  int n_cmp;
  int n_bad;

  data_status_pipe_vr #(
    .DATA_W(8), .STATUS_W(2), .PIPE_DEPTH(4), .INCLUDE_DATA_IN(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .data_i(data_i), .status_i(status_i),
    .out_valid(out_valid), .out_ready(out_ready), .data_o(data_o), .status_o(status_o),
    .valid_tap_o(valid_tap_o), .data_tap_o(data_tap_o), .status_tap_o(status_tap_o),
    .count_o(count_o)
  );

  data_status_pipe_vr #(
    .DATA_W(8), .STATUS_W(2), .PIPE_DEPTH(1), .INCLUDE_DATA_IN(1)
  ) dut_wire (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .data_i(w_data_i), .status_i(w_status_i),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .data_o(w_data_o), .status_o(w_status_o),
    .valid_tap_o(w_valid_tap_o), .data_tap_o(w_data_tap_o), .status_tap_o(w_status_tap_o),
    .count_o(w_count_o)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #20;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    n_cmp++; if (status_tap_o !== 8'h00) begin n_bad++; $display("FAIL reset_status_taps: got %h expected 00", status_tap_o); end
    n_cmp++; if (valid_tap_o !== 4'b0000) begin n_bad++; $display("FAIL reset_valid_taps: got %b expected 0000", valid_tap_o); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (status_o !== 2'd0) begin n_bad++; $display("FAIL reset_status_o: got %h expected 0", status_o); end
    rst_n = 1'b1;
    #5;
    clk_en = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    int accepted;
    int popped;
    logic       exp_v;
    logic [2:0] exp_c;
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      in_valid = (n < 8);
      data_i   = 8'(8'h11 + n);
      status_i = 2'd1;
      #1;
      if (n < 8) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", n, in_ready); end
      end
      tick();
      accepted = (n + 1 < 8) ? n + 1 : 8;
      popped   = (n - 3 > 0) ? n - 3 : 0;
      exp_v    = (n >= 3) && (n <= 10);
      exp_c    = 3'(accepted - popped);
      n_cmp++; if (out_valid !== exp_v) begin n_bad++; $display("FAIL stream_out_valid[%0d]: got %b expected %b", n, out_valid, exp_v); end
      n_cmp++; if (count_o !== exp_c) begin n_bad++; $display("FAIL stream_count[%0d]: got %0d expected %0d", n, count_o, exp_c); end
      n_cmp++; if (status_o !== (exp_v ? 2'd1 : 2'd0)) begin n_bad++; $display("FAIL stream_status[%0d]: got %h expected %h", n, status_o, exp_v ? 2'd1 : 2'd0); end
      if (exp_v) begin
        n_cmp++; if (data_o !== 8'(8'h11 + n - 3)) begin n_bad++; $display("FAIL stream_data[%0d]: got %h expected %h", n, data_o, 8'(8'h11 + n - 3)); end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c % 2 == 0) && (c < 5);
      data_i   = 8'(8'h21 + c / 2);
      status_i = 2'd2;
      tick();
      if (c == 4) begin
        n_cmp++; if (count_o !== 3'd3) begin n_bad++; $display("FAIL bp_count3: got %0d expected 3", count_o); end
      end
    end
    n_cmp++; if (valid_tap_o !== 4'b1110) begin n_bad++; $display("FAIL bp_packed_valid: got %b expected 1110", valid_tap_o); end
    n_cmp++; if (data_tap_o[3] !== 8'h21 || data_tap_o[2] !== 8'h22 || data_tap_o[1] !== 8'h23) begin
      n_bad++; $display("FAIL bp_packed_data: got %h expected 212223xx", data_tap_o);
    end
    // Fill the last slot.
    in_valid = 1'b1;
    data_i   = 8'h24;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_fill_ready: got %b expected 1", in_ready); end
    tick();
    n_cmp++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL bp_count4: got %0d expected 4", count_o); end
    data_i = 8'h25;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b expected 0", in_ready); end
    tick();
    n_cmp++; if (count_o !== 3'd4 || data_tap_o[0] !== 8'h24) begin n_bad++; $display("FAIL bp_hold: got count %0d tap0 %h expected 4 24", count_o, data_tap_o[0]); end
    // Release backpressure and drain.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = 8'(8'h21 + k);
      #1;
      n_cmp++; if (out_valid !== 1'b1 || data_o !== exp_d) begin n_bad++; $display("FAIL bp_drain[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_valid, data_o, exp_d); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0 || count_o !== 3'd0) begin n_bad++; $display("FAIL bp_empty: got v=%b c=%0d expected v=0 c=0", out_valid, count_o); end
  endtask

  task automatic test_flush();
    int seen;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 3);
      data_i   = 8'(8'h31 + c);
      status_i = 2'd3;
      tick();
    end
    n_cmp++; if (count_o !== 3'd3 || valid_tap_o !== 4'b1110) begin n_bad++; $display("FAIL flush_pre: got c=%0d v=%b expected c=3 v=1110", count_o, valid_tap_o); end
    flush     = 1'b1;
    in_valid  = 1'b1;
    data_i    = 8'h3F;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || data_o !== 8'h31) begin n_bad++; $display("FAIL flush_cycle_out: got v=%b d=%h expected v=1 d=31", out_valid, data_o); end
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (count_o !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    n_cmp++; if (out_valid !== 1'b0 || valid_tap_o !== 4'b0000) begin n_bad++; $display("FAIL flush_valid: got v=%b taps=%b expected 0 0000", out_valid, valid_tap_o); end
    n_cmp++; if (status_tap_o !== 8'h00) begin n_bad++; $display("FAIL flush_status: got %h expected 00", status_tap_o); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL flush_absent: got %0d words expected 0", seen); end
  endtask

  task automatic test_wire();
    logic r;
    w_in_valid = 1'b1;
    w_data_i   = 8'hA5;
    w_status_i = 2'd2;
    for (int k = 0; k < 4; k++) begin
      r = (k % 2 == 1);
      w_out_ready = r;
      #1;
      n_cmp++; if (w_out_valid !== 1'b1 || w_data_o !== 8'hA5 || w_status_o !== 2'd2) begin
        n_bad++; $display("FAIL wire_out[%0d]: got v=%b d=%h s=%h expected 1 a5 2", k, w_out_valid, w_data_o, w_status_o);
      end
      n_cmp++; if (w_in_ready !== r) begin n_bad++; $display("FAIL wire_ready[%0d]: got %b expected %b", k, w_in_ready, r); end
      tick();
    end
    n_cmp++; if (w_count_o !== 1'b0 || w_valid_tap_o !== 1'b1 || w_data_tap_o[0] !== 8'hA5 || w_status_tap_o[0] !== 2'd2) begin
      n_bad++; $display("FAIL wire_tap: got c=%b v=%b d=%h s=%h expected 0 1 a5 2", w_count_o, w_valid_tap_o, w_data_tap_o[0], w_status_tap_o[0]);
    end
    w_in_valid = 1'b0;
    #1;
    n_cmp++; if (w_out_valid !== 1'b0) begin n_bad++; $display("FAIL wire_idle: got %b expected 0", w_out_valid); end
  endtask

  task automatic test_async_reset();
    int lat;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      data_i   = 8'(8'h41 + c);
      status_i = 2'd1;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (count_o !== 3'd4) begin n_bad++; $display("FAIL areset_pre: got %0d expected 4", count_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || count_o !== 3'd0 || valid_tap_o !== 4'b0000) begin
      n_bad++; $display("FAIL areset_now: got v=%b c=%0d taps=%b expected 0 0 0000", out_valid, count_o, valid_tap_o);
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL areset_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    in_valid  = 1'b1;
    data_i    = 8'h51;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL areset_latency: got %0d expected 4", lat); end
    n_cmp++; if (data_o !== 8'h51) begin n_bad++; $display("FAIL areset_data: got %h expected 51", data_o); end
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    clk_en      = 1'b0;
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    data_i      = 8'h00;
    status_i    = 2'd0;
    out_ready   = 1'b1;
    w_in_valid  = 1'b0;
    w_data_i    = 8'h00;
    w_status_i  = 2'd0;
    w_out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_wire();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_status_pipe_vr.md
# data_status_pipe_vr

Parametrised valid/ready successor to the enable-driven data/status shift register. It carries a data word and a status word through a configurable number of registered stages under per-stage flow control. Bubbles collapse: each stage advances independently into an empty or draining successor. A synchronous flush clears the pipeline. Intended for the Ethernet parser datapath wherever byte/flag pipelines must tolerate downstream backpressure while still exposing every stage as a tap.

## Interface
- DATA_W, 32, data width per stage
- STATUS_W, 1, status width per stage
- PIPE_DEPTH, 1, number of tap entries (>=1)
- INCLUDE_DATA_IN, 0, 1: tap[0] is the combinational input and registered stage count R = PIPE_DEPTH-1; 0: R = PIPE_DEPTH
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all stages
- in_valid  in  1  input word valid
- in_ready  out  1  input accepted when in_valid && in_ready
- data_i  in  DATA_W  input data
- status_i  in  STATUS_W  input status
- out_valid  out  1  last stage holds a word
- out_ready  in  1  consumer accepts the last-stage word
- data_o  out  DATA_W  last-stage data
- status_o  out  STATUS_W  last-stage status
- valid_tap_o  out  1 x [PIPE_DEPTH]  per-tap valid
- data_tap_o  out  DATA_W x [PIPE_DEPTH]  per-tap data
- status_tap_o  out  STATUS_W x [PIPE_DEPTH]  per-tap status
- count_o  out  $clog2(R+1)  number of valid registered stages; 1 bit when R=0

## Operation
- Each stage k holds v[k], d[k], s[k]. Stage 0 is fed by the input; the last stage drives out_*.
- Drain: move[last] = v[last] && out_ready.
- Load: stage k loads from its predecessor when it is empty or draining, i.e. take[k] = !v[k] || move[k]. The predecessor moves when it is valid and take[k] holds. in_ready = take[0].
- The ready path is combinational from out_ready through all stages to in_ready. It is an accepted critical path; callers add a register slice when R is large.
- A stage that drains without a refill sets v=0 and s=0. Its data holds its old value.
- Taps: with INCLUDE_DATA_IN=1, tap[0] = {in_valid, data_i, status_i} and tap[i] = stage i-1. With INCLUDE_DATA_IN=0, tap[i] = stage i.
- R=0 (PIPE_DEPTH=1, INCLUDE_DATA_IN=1) is a pure wire: out_* = in_*, in_ready = out_ready, count_o = 0.
- flush=1: at the next edge all v=0 and s=0. in_ready=0 during the flush cycle, so input is neither accepted nor stored. out_valid still reflects the current contents, but nothing is popped by the block; a consumer handshake in that cycle is discarded. Flush has priority over every move.
- count_o is the registered population count of v. It updates on the same edge as the stage valids.

## Timing
- Reset (rst_n low, asynchronous): v=0, s=0, count_o=0, out_valid=0, status_o=0, and in_ready=1 when R>0. Data registers: see Configuration.
- Release of rst_n is sampled synchronously by the first rising edge.
- Latency: a word accepted at edge t into an empty pipe is on out_* after edge t+R-1, with out_valid=1 in the cycle following edge t+R-1. That is R cycles from acceptance to presentation, counting the acceptance cycle.
- Throughput: 1 word/cycle while out_ready=1.
- Full pipe with out_ready=0: in_ready=0 and all stages hold.
- Full pipe with out_ready=1: pass-through at full rate, in_ready=1.
- Simultaneous drain and refill of a stage keeps v=1 with the new data.
- Reset asserted mid-stream discards all contents immediately, without waiting for a clock edge.

## Configuration
- DATA_STATUS_PIPE_DATA_RST_EN defined: data registers also reset asynchronously to 0, and flush also zeroes them.
- DATA_STATUS_PIPE_DATA_RST_EN undefined: data registers have no reset and flush leaves them untouched, which keeps area low. Only valid, status and count are reset/cleared, and data_o/data_tap_o are X after reset until written.

## Test plan
- Setup for all scenarios unless stated: DATA_W=8, STATUS_W=2, PIPE_DEPTH=4, INCLUDE_DATA_IN=0.
- Reset: rst_n low with clk stopped -> out_valid=0, count_o=0, all status_tap_o=0, in_ready=1.
- Streaming: send 0x11..0x18 with status 1, out_ready=1 -> out_valid rises 4 cycles after the first accept. Output 0x11..0x18 appears back-to-back with no gaps, and count_o holds at 4 during the steady state.
- Backpressure and bubble collapse:
  - Input words in cycles 0, 2 and 4; out_ready=0 -> count_o reaches 3 and the words are packed in stages 3, 2, 1.
  - Fill to 4 -> in_ready=0.
  - Then out_ready=1 -> words emerge in order 1/cycle.
- Flush: pipe holds 3 words and flush is pulsed with in_valid=1 -> next cycle count_o=0, out_valid=0, status taps 0, and the flush-cycle input is absent from the output.
- Wire mode: PIPE_DEPTH=1, INCLUDE_DATA_IN=1; in_valid=1, data 0xA5, out_ready toggling -> out_* equals in_* combinationally and in_ready tracks out_ready.
- Async reset mid-stream: assert rst_n between clock edges with 4 valid words -> out_valid=0 immediately. After release, the first new word emerges with latency 4.
